conv_sched: RTL and testbench

Sequencer and arbiter for the shared decimal-to-binary operand converter of the calculator datapath. Two operand-entry requesters (A and B) each present a keypad digit bundle. The block grants the single converter to one requester at a time, aligns the converter's free-running 16-cycle frame by pulsing its reset, and captures the 12-bit fixed-point result. It then holds both operands for the ALU behind a valid/ack handshake.

---
 rtl/conv_sched.sv | 134 +++++++++++++
 tb/tb_conv_sched.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_sched.sv
// Shares one decimal-to-binary converter between operand requesters A and B.
// It primes the converter frame, captures the result and holds both operands for the ALU.
module conv_sched #(
  parameter int TIMEOUT = 40
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_a,
  input  logic        req_b,
  input  logic [39:0] a_dig,
  input  logic [39:0] b_dig,
  output logic [39:0] conv_dig,
  output logic        conv_rst_n,
  input  logic        conv_done,
  input  logic [11:0] conv_digit,
  output logic        ack_a,
  output logic        ack_b,
  output logic [11:0] op_a,
  output logic [11:0] op_b,
  output logic        a_ok,
  output logic        b_ok,
  output logic        ops_valid,
  input  logic        alu_ack,
  output logic        busy,
  output logic        err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, PRIME, WAIT1, WAIT2, CAPT} state_t;

  state_t        state_reg;
  logic [CW-1:0] cnt_reg;
  logic          done_q_reg;
  logic          last_b_reg;
  logic          owner_b_reg;

  logic pend_a;
  logic pend_b;
  logic grant;
  logic grant_b;
  logic done_rise;
  logic timeout_hit;

  // A requester whose ack is currently showing is finished and must not be re-granted.
  always_comb begin
    pend_a      = req_a & ~ack_a;
    pend_b      = req_b & ~ack_b;
    grant       = ((state_reg == IDLE) || (state_reg == CAPT)) && (pend_a || pend_b);
    grant_b     = pend_b & (~pend_a | ~last_b_reg);
    done_rise   = conv_done & ~done_q_reg;
    timeout_hit = ((state_reg == WAIT1) || (state_reg == WAIT2)) &&
                  (cnt_reg == CW'(TIMEOUT - 1));
  end

  assign ops_valid = a_ok & b_ok;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      done_q_reg  <= 1'b0;
      last_b_reg  <= 1'b1;
      owner_b_reg <= 1'b0;
      conv_dig    <= '0;
      conv_rst_n  <= 1'b0;
      ack_a       <= 1'b0;
      ack_b       <= 1'b0;
      op_a        <= '0;
      op_b        <= '0;
      a_ok        <= 1'b0;
      b_ok        <= 1'b0;
      busy        <= 1'b0;
      err         <= 1'b0;
    end else begin
      done_q_reg <= conv_done;
      conv_rst_n <= 1'b1;
      ack_a      <= 1'b0;
      ack_b      <= 1'b0;
      if (alu_ack) begin
        a_ok <= 1'b0;
        b_ok <= 1'b0;
      end
      case (state_reg)
        IDLE, CAPT: begin
          if (grant) begin
            state_reg   <= PRIME;
            conv_dig    <= grant_b ? b_dig : a_dig;
            last_b_reg  <= grant_b;
            owner_b_reg <= grant_b;
            conv_rst_n  <= 1'b0;
            busy        <= 1'b1;
          end else begin
            state_reg <= IDLE;
            busy      <= 1'b0;
          end
        end
        PRIME: begin
          state_reg <= WAIT1;
          cnt_reg   <= '0;
        end
        WAIT1, WAIT2: begin
          cnt_reg <= cnt_reg + CW'(1);
          // A capture overrides a same-cycle alu_ack clear for the captured operand.
          if ((state_reg == WAIT2) && done_rise) begin
            state_reg <= CAPT;
            if (owner_b_reg) begin
              op_b  <= conv_digit;
              b_ok  <= 1'b1;
              ack_b <= 1'b1;
            end else begin
              op_a  <= conv_digit;
              a_ok  <= 1'b1;
              ack_a <= 1'b1;
            end
          end else if (timeout_hit) begin
            state_reg <= IDLE;
            busy      <= 1'b0;
            err       <= 1'b1;
            if (owner_b_reg) ack_b <= 1'b1;
            else             ack_a <= 1'b1;
          end else if (done_rise) begin
            state_reg <= WAIT2;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_sched.sv
// Bench for conv_sched: behavioural 16-cycle converter plus an operand scoreboard.
module tb_conv_sched;
  localparam int TIMEOUT = 40;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        req_a = 1'b0;
  logic        req_b = 1'b0;
  logic [39:0] a_dig = '0;
  logic [39:0] b_dig = '0;
  logic [39:0] conv_dig;
  logic        conv_rst_n;
  logic        conv_done;
  logic [11:0] conv_digit;
  logic        ack_a, ack_b;
  logic [11:0] op_a, op_b;
  logic        a_ok, b_ok, ops_valid;
  logic        alu_ack = 1'b0;
  logic        busy, err;

  int checks = 0;
  int failures = 0;

  logic [11:0] exp_op_a = '0;
  logic [11:0] exp_op_b = '0;
  logic        exp_a_ok = 1'b0;
  logic        exp_b_ok = 1'b0;
  bit          exp_last_b = 1'b1;

  logic [3:0] ccnt = 4'd0;
  bit         stuck0 = 1'b0;
  bit         stuck1 = 1'b0;
  logic       frame_done;

  function automatic int low_idx(input logic [9:0] f);
    for (int i = 0; i < 10; i++) if (f[i]) return i;
    return 0;
  endfunction

  function automatic logic [11:0] ref_conv(input logic [39:0] d);
    int ip;
    int fp;
    ip = low_idx(d[39:30]) * 10 + low_idx(d[29:20]);
    fp = (low_idx(d[19:10]) * 10 + low_idx(d[9:0])) * 256 / 100;
    return {4'(ip), 8'(fp)};
  endfunction

  function automatic logic [39:0] rand_dig();
    logic [39:0] d;
    logic [9:0]  f;
    d = '0;
    for (int k = 0; k < 4; k++) begin
      if ($urandom_range(0, 3) == 0) f = 10'($urandom);
      else                           f = 10'd1 << $urandom_range(0, 9);
      d = {d[29:0], f};
    end
    return d;
  endfunction

  always #5 CLK = ~CLK;

  // Converter: frame counter restarts while held in reset, done high for counts 10..14.
  always @(posedge CLK) begin
    if (conv_rst_n !== 1'b1) ccnt <= 4'd0;
    else                     ccnt <= ccnt + 4'd1;
  end
  assign frame_done = (ccnt >= 4'd10) && (ccnt <= 4'd14);
  assign conv_done  = stuck1 | (frame_done & ~stuck0);
  assign conv_digit = frame_done ? ref_conv(conv_dig) : {8'hA5, ccnt};

  conv_sched #(.TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST(RST), .req_a(req_a), .req_b(req_b), .a_dig(a_dig), .b_dig(b_dig),
    .conv_dig(conv_dig), .conv_rst_n(conv_rst_n), .conv_done(conv_done),
    .conv_digit(conv_digit), .ack_a(ack_a), .ack_b(ack_b), .op_a(op_a), .op_b(op_b),
    .a_ok(a_ok), .b_ok(b_ok), .ops_valid(ops_valid), .alu_ack(alu_ack),
    .busy(busy), .err(err)
  );

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic model_reset();
    exp_op_a = '0; exp_op_b = '0; exp_a_ok = 1'b0; exp_b_ok = 1'b0; exp_last_b = 1'b1;
  endtask

  task automatic wait_prime(input int limit, output bit ok);
    int n;
    n = 0;
    while (!(busy === 1'b1 && conv_rst_n === 1'b0) && n < limit) begin
      tick();
      n++;
    end
    ok = (busy === 1'b1 && conv_rst_n === 1'b0);
  endtask

  // Latency counts from the PRIME cycle (cycle 0) to the cycle ack is visible.
  task automatic wait_xact(input int limit, output int lat, output logic [39:0] pdig,
                           output logic [1:0] acks, output bit ok);
    bit p;
    lat = -1; pdig = 'x; acks = 2'b00; ok = 1'b0;
    wait_prime(limit, p);
    if (!p) return;
    pdig = conv_dig;
    lat = 0;
    while (ack_a !== 1'b1 && ack_b !== 1'b1 && lat < limit) begin
      tick();
      lat++;
    end
    acks = {ack_b, ack_a};
    ok = (ack_a === 1'b1) || (ack_b === 1'b1);
  endtask

  task automatic test_reset();
    RST = 1'b0;
    repeat (3) tick();
    checks++;
    if ({conv_rst_n, conv_dig, op_a, op_b, a_ok, b_ok, ack_a, ack_b, busy, err, ops_valid} !== 72'd0) begin
      failures++;
      $display("FAIL reset_values: got %h required 0",
               {conv_rst_n, conv_dig, op_a, op_b, a_ok, b_ok, ack_a, ack_b, busy, err, ops_valid});
    end
    RST = 1'b1;
    tick();
    checks++;
    if ({conv_rst_n, busy} !== 2'b10) begin
      failures++;
      $display("FAIL release_idle: conv_rst_n,busy got %b required 10", {conv_rst_n, busy});
    end
    model_reset();
  endtask

  task automatic test_single();
    int lat; logic [39:0] pdig; logic [1:0] acks; bit ok;
    a_dig = {10'h001, 10'h008, 10'h004, 10'h020};
    req_a = 1'b1;
    wait_xact(80, lat, pdig, acks, ok);
    req_a = 1'b0;
    exp_op_a = ref_conv(a_dig); exp_a_ok = 1'b1; exp_last_b = 1'b0;
    checks++;
    if (!ok || lat != 28) begin
      failures++; $display("FAIL single_latency: got %0d required 28", lat);
    end
    checks++;
    if (pdig !== a_dig) begin
      failures++; $display("FAIL single_conv_dig: got %h required %h", pdig, a_dig);
    end
    checks++;
    if (acks !== 2'b01) begin
      failures++; $display("FAIL single_ack: got %b required 01", acks);
    end
    checks++;
    if (op_a !== 12'h340) begin
      failures++; $display("FAIL single_op_a: got %h required 340", op_a);
    end
    checks++;
    if ({a_ok, b_ok, ops_valid} !== 3'b100) begin
      failures++; $display("FAIL single_flags: got %b required 100", {a_ok, b_ok, ops_valid});
    end
    tick();
    checks++;
    if ({ack_a, busy} !== 2'b00) begin
      failures++; $display("FAIL single_after_ack: ack_a,busy got %b required 00", {ack_a, busy});
    end
  endtask

  task automatic test_tie_alu_ack();
    int lat; logic [39:0] pdig; logic [1:0] acks; bit ok;
    RST = 1'b0;
    repeat (2) tick();
    a_dig = rand_dig(); b_dig = rand_dig();
    req_a = 1'b1; req_b = 1'b1;
    RST = 1'b1;
    model_reset();
    wait_xact(80, lat, pdig, acks, ok);
    req_a = 1'b0;
    exp_op_a = ref_conv(a_dig); exp_a_ok = 1'b1;
    checks++;
    if (!ok || lat != 28 || acks !== 2'b01 || pdig !== a_dig) begin
      failures++; $display("FAIL tie_first_a: lat %0d acks %b dig %h required 28 01 %h", lat, acks, pdig, a_dig);
    end
    tick();
    checks++;
    if (busy !== 1'b1 || conv_rst_n !== 1'b0 || conv_dig !== b_dig) begin
      failures++; $display("FAIL tie_b_grant_next_edge: busy %b conv_rst_n %b dig %h required 1 0 %h",
                           busy, conv_rst_n, conv_dig, b_dig);
    end
    wait_xact(80, lat, pdig, acks, ok);
    req_b = 1'b0;
    exp_op_b = ref_conv(b_dig); exp_b_ok = 1'b1; exp_last_b = 1'b1;
    checks++;
    if (!ok || lat != 28 || acks !== 2'b10) begin
      failures++; $display("FAIL tie_second_b: lat %0d acks %b required 28 10", lat, acks);
    end
    checks++;
    if ({op_a, op_b, a_ok, b_ok, ops_valid} !== {exp_op_a, exp_op_b, 3'b111}) begin
      failures++; $display("FAIL tie_ops_valid: got %h required %h",
                           {op_a, op_b, a_ok, b_ok, ops_valid}, {exp_op_a, exp_op_b, 3'b111});
    end
    alu_ack = 1'b1;
    tick();
    alu_ack = 1'b0;
    exp_a_ok = 1'b0; exp_b_ok = 1'b0;
    checks++;
    if ({op_a, op_b, a_ok, b_ok, ops_valid} !== {exp_op_a, exp_op_b, 3'b000}) begin
      failures++; $display("FAIL alu_ack_clear: got %h required %h",
                           {op_a, op_b, a_ok, b_ok, ops_valid}, {exp_op_a, exp_op_b, 3'b000});
    end
  endtask

  task automatic test_capture_collision();
    int lat; logic [39:0] pdig; logic [1:0] acks; bit ok;
    a_dig = rand_dig();
    req_a = 1'b1;
    wait_xact(80, lat, pdig, acks, ok);
    req_a = 1'b0;
    exp_op_a = ref_conv(a_dig); exp_a_ok = 1'b1;
    tick();
    b_dig = rand_dig();
    req_b = 1'b1;
    wait_prime(80, ok);
    checks++;
    if (!ok) begin
      failures++; $display("FAIL collision_prime: got no grant required grant of B");
    end
    repeat (27) tick();
    alu_ack = 1'b1;
    tick();
    alu_ack = 1'b0;
    req_b = 1'b0;
    exp_op_b = ref_conv(b_dig); exp_b_ok = 1'b1; exp_a_ok = 1'b0; exp_last_b = 1'b1;
    checks++;
    if ({ack_b, b_ok, a_ok, ops_valid} !== 4'b1100) begin
      failures++; $display("FAIL collision_flags: ack_b,b_ok,a_ok,ops_valid got %b required 1100",
                           {ack_b, b_ok, a_ok, ops_valid});
    end
    checks++;
    if ({op_a, op_b} !== {exp_op_a, exp_op_b}) begin
      failures++; $display("FAIL collision_ops: got %h required %h", {op_a, op_b}, {exp_op_a, exp_op_b});
    end
    alu_ack = 1'b1;
    tick();
    alu_ack = 1'b0;
    exp_b_ok = 1'b0;
  endtask

  task automatic test_timeout();
    int lat; logic [39:0] pdig; logic [1:0] acks; bit ok;
    stuck0 = 1'b1;
    a_dig = rand_dig();
    req_a = 1'b1;
    wait_xact(80, lat, pdig, acks, ok);
    req_a = 1'b0;
    exp_last_b = 1'b0;
    checks++;
    if (!ok || lat != TIMEOUT + 1 || acks !== 2'b01) begin
      failures++; $display("FAIL timeout_low_ack: lat %0d acks %b required %0d 01", lat, acks, TIMEOUT + 1);
    end
    checks++;
    if ({err, a_ok, busy} !== 3'b100 || op_a !== exp_op_a) begin
      failures++; $display("FAIL timeout_low_state: err,a_ok,busy %b op_a %h required 100 %h",
                           {err, a_ok, busy}, op_a, exp_op_a);
    end
    tick();
    stuck0 = 1'b0;
    checks++;
    if ({ack_a, busy, err} !== 3'b001) begin
      failures++; $display("FAIL timeout_idle: ack_a,busy,err got %b required 001", {ack_a, busy, err});
    end
    stuck1 = 1'b1;
    repeat (2) tick();
    b_dig = rand_dig();
    req_b = 1'b1;
    wait_xact(80, lat, pdig, acks, ok);
    req_b = 1'b0;
    exp_last_b = 1'b1;
    checks++;
    if (!ok || lat != TIMEOUT + 1 || acks !== 2'b10) begin
      failures++; $display("FAIL timeout_high_ack: lat %0d acks %b required %0d 10", lat, acks, TIMEOUT + 1);
    end
    checks++;
    if ({err, b_ok} !== 2'b10 || op_b !== exp_op_b) begin
      failures++; $display("FAIL timeout_high_state: err,b_ok %b op_b %h required 10 %h",
                           {err, b_ok}, op_b, exp_op_b);
    end
    tick();
    stuck1 = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_reset_mid();
    int lat; logic [39:0] pdig; logic [1:0] acks; bit ok;
    b_dig = rand_dig();
    req_b = 1'b1;
    wait_prime(80, ok);
    repeat (15) tick();
    RST = 1'b0;
    tick();
    model_reset();
    checks++;
    if ({conv_rst_n, conv_dig, op_a, op_b, a_ok, b_ok, ack_a, ack_b, busy, err, ops_valid} !== 72'd0) begin
      failures++;
      $display("FAIL midop_reset_values: got %h required 0",
               {conv_rst_n, conv_dig, op_a, op_b, a_ok, b_ok, ack_a, ack_b, busy, err, ops_valid});
    end
    RST = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b1 || conv_rst_n !== 1'b0 || conv_dig !== b_dig) begin
      failures++; $display("FAIL midop_regrant: busy %b conv_rst_n %b dig %h required 1 0 %h",
                           busy, conv_rst_n, conv_dig, b_dig);
    end
    wait_xact(80, lat, pdig, acks, ok);
    req_b = 1'b0;
    exp_op_b = ref_conv(b_dig); exp_b_ok = 1'b1; exp_last_b = 1'b1;
    checks++;
    if (!ok || lat != 28 || acks !== 2'b10 || {op_a, op_b} !== {exp_op_a, exp_op_b}) begin
      failures++; $display("FAIL midop_finish: lat %0d acks %b ops %h required 28 10 %h",
                           lat, acks, {op_a, op_b}, {exp_op_a, exp_op_b});
    end
    tick();
  endtask

  task automatic test_random();
    int lat; logic [39:0] pdig; logic [1:0] acks; bit ok;
    int mode; int n; bit first_b; bit cur_b;
    for (int it = 0; it < 12; it++) begin
      mode = int'($urandom_range(0, 2));
      a_dig = rand_dig(); b_dig = rand_dig();
      req_a = (mode != 1); req_b = (mode != 0);
      first_b = (mode == 1) || (mode == 2 && !exp_last_b);
      n = (mode == 2) ? 2 : 1;
      for (int k = 0; k < n; k++) begin
        cur_b = (k == 0) ? first_b : !first_b;
        wait_xact(80, lat, pdig, acks, ok);
        if (cur_b) req_b = 1'b0; else req_a = 1'b0;
        if (cur_b) begin exp_op_b = ref_conv(b_dig); exp_b_ok = 1'b1; end
        else       begin exp_op_a = ref_conv(a_dig); exp_a_ok = 1'b1; end
        exp_last_b = cur_b;
        checks++;
        if (!ok || lat != 28 || acks !== (cur_b ? 2'b10 : 2'b01) || pdig !== (cur_b ? b_dig : a_dig)) begin
          failures++; $display("FAIL rand_xact it%0d: lat %0d acks %b dig %h required 28 %b %h",
                               it, lat, acks, pdig, cur_b ? 2'b10 : 2'b01, cur_b ? b_dig : a_dig);
        end
        checks++;
        if ({op_a, op_b, a_ok, b_ok, ops_valid} !== {exp_op_a, exp_op_b, exp_a_ok, exp_b_ok, exp_a_ok & exp_b_ok}) begin
          failures++; $display("FAIL rand_ops it%0d: got %h required %h", it,
                               {op_a, op_b, a_ok, b_ok, ops_valid},
                               {exp_op_a, exp_op_b, exp_a_ok, exp_b_ok, exp_a_ok & exp_b_ok});
        end
      end
      if ($urandom_range(0, 1) == 1) begin
        alu_ack = 1'b1;
        tick();
        alu_ack = 1'b0;
        exp_a_ok = 1'b0; exp_b_ok = 1'b0;
      end
      repeat ($urandom_range(1, 3)) tick();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_tie_alu_ack();
    test_capture_collision();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
